// File: rtl/jtag_pkg.sv
// jtag_pkg: shared constants for the JTAG instruction/data register bank.
//   - opcode constants (4-bit encodings, resized to IR_WIDTH at use)
//   - default instruction register width
//   - IR capture pattern (low two bits of the IR shift register on Capture-IR)
package jtag_pkg;

    localparam int          JTAG_IR_WIDTH   = 4;

    localparam logic [3:0]  JTAG_IDCODE     = 4'b0001;
    localparam logic [3:0]  JTAG_USER       = 4'b0010;
    localparam logic [3:0]  JTAG_BYPASS     = 4'b1111;

    // Mandatory "01" in the two LSBs lets a board-level scan detect IR length.
    localparam logic [1:0]  JTAG_IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg: generic capture/shift/update register, LSB-first.
//   clk, rst_n      : clock, synchronous active-low reset
//   capture         : load cap_value into the shift stage
//   shift           : sr <= {tdi, sr[WIDTH-1:1]}
//   update          : copy shift stage into the parallel update stage
//   preset          : force update stage to UPD_RST (wins over update)
//   tdi / so        : serial in / serial out (sr[0])
//   cap_value       : parallel capture value
//   upd_q           : parallel update stage
// Caller guarantees at most one of capture/shift/update is active.
module jtag_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] UPD_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             shift,
    input  logic             update,
    input  logic             preset,
    input  logic             tdi,
    input  logic [WIDTH-1:0] cap_value,
    output logic             so,
    output logic [WIDTH-1:0] upd_q
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;

    // Arithmetic form stays legal for WIDTH == 1, where a part-select would not.
    assign sr_shifted = (sr >> 1) | (WIDTH'(tdi) << (WIDTH - 1));
    assign so         = sr[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr    <= '0;
            upd_q <= UPD_RST;
        end else begin
            if (capture)
                sr <= cap_value;
            else if (shift)
                sr <= sr_shifted;

            if (preset)
                upd_q <= UPD_RST;
            else if (update)
                upd_q <= sr;
        end
    end

endmodule

// File: rtl/jtag_data_regs.sv
// jtag_data_regs: IR plus IDCODE / BYPASS / USER data registers behind a TAP.
//   tck, trst           : clock, synchronous active-low reset
//   tdi / tdo, tdo_oe   : serial in, serial out, output enable in Shift-IR/DR
//   *_state             : one-hot TAP state indicators from the controller
//   user_capture        : parallel value captured into USER on Capture-DR
//   instruction         : latched instruction
//   user_out            : last updated USER value
//   user_update         : one-cycle pulse coincident with user_out loading
// Illegal multi-hot strobes resolve as reset-state > IR group > DR group,
// and capture > shift > update within a group.
module jtag_data_regs
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = JTAG_IR_WIDTH,
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5677,
    parameter int          USER_WIDTH   = 8
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  tdi,
    input  logic                  test_logic_reset_state,
    input  logic                  capture_dr_state,
    input  logic                  shift_dr_state,
    input  logic                  update_dr_state,
    input  logic                  capture_ir_state,
    input  logic                  shift_ir_state,
    input  logic                  update_ir_state,
    input  logic [USER_WIDTH-1:0] user_capture,
    output logic                  tdo,
    output logic                  tdo_oe,
    output logic [IR_WIDTH-1:0]   instruction,
    output logic [USER_WIDTH-1:0] user_out,
    output logic                  user_update
);

    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(JTAG_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(JTAG_USER);
    localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(JTAG_IR_CAPTURE);

    // ---- strobe priority decode ----
    logic tlr, ir_any, dr_any;
    logic ir_cap, ir_shift, ir_upd;
    logic dr_cap, dr_shift, dr_upd;

    assign tlr      = test_logic_reset_state;
    assign ir_any   = capture_ir_state | shift_ir_state | update_ir_state;
    assign ir_cap   = !tlr && capture_ir_state;
    assign ir_shift = !tlr && !capture_ir_state && shift_ir_state;
    assign ir_upd   = !tlr && !capture_ir_state && !shift_ir_state && update_ir_state;
    assign dr_any   = !tlr && !ir_any;
    assign dr_cap   = dr_any && capture_dr_state;
    assign dr_shift = dr_any && !capture_dr_state && shift_dr_state;
    assign dr_upd   = dr_any && !capture_dr_state && !shift_dr_state && update_dr_state;

    // ---- DR selection from the currently latched instruction ----
    // Anything other than IDCODE or USER falls back to BYPASS.
    logic sel_idcode, sel_user, sel_bypass;

    assign sel_idcode = (instruction == OP_IDCODE);
    assign sel_user   = (instruction == OP_USER);
    assign sel_bypass = !sel_idcode && !sel_user;

    // ---- instruction register ----
    logic ir_so;

    jtag_shift_reg #(
        .WIDTH   (IR_WIDTH),
        .UPD_RST (OP_IDCODE)
    ) u_ir (
        .clk       (tck),
        .rst_n     (trst),
        .capture   (ir_cap),
        .shift     (ir_shift),
        .update    (ir_upd),
        .preset    (tlr),
        .tdi       (tdi),
        .cap_value (IR_CAP),
        .so        (ir_so),
        .upd_q     (instruction)
    );

    // ---- IDCODE register (read-only: update stage never loads) ----
    logic        idcode_so;
    logic [31:0] idcode_upd_unused;

    jtag_shift_reg #(
        .WIDTH   (32),
        .UPD_RST ('0)
    ) u_idcode (
        .clk       (tck),
        .rst_n     (trst),
        .capture   (dr_cap && sel_idcode),
        .shift     (dr_shift && sel_idcode),
        .update    (1'b0),
        .preset    (1'b0),
        .tdi       (tdi),
        .cap_value (IDCODE_VALUE),
        .so        (idcode_so),
        .upd_q     (idcode_upd_unused)
    );

    // ---- USER register ----
    logic user_so;
    logic user_load;

    assign user_load = dr_upd && sel_user;

    jtag_shift_reg #(
        .WIDTH   (USER_WIDTH),
        .UPD_RST ('0)
    ) u_user (
        .clk       (tck),
        .rst_n     (trst),
        .capture   (dr_cap && sel_user),
        .shift     (dr_shift && sel_user),
        .update    (user_load),
        .preset    (1'b0),
        .tdi       (tdi),
        .cap_value (user_capture),
        .so        (user_so),
        .upd_q     (user_out)
    );

    // ---- BYPASS flop and update pulse ----
    logic bypass_q;

    always_ff @(posedge tck) begin
        if (!trst) begin
            bypass_q    <= 1'b0;
            user_update <= 1'b0;
        end else begin
            if (dr_cap && sel_bypass)
                bypass_q <= 1'b0;
            else if (dr_shift && sel_bypass)
                bypass_q <= tdi;
            // Pulse lines up with the cycle in which user_out shows the new value.
            user_update <= user_load;
        end
    end

    // ---- serial output ----
    assign tdo_oe = shift_dr_state | shift_ir_state;

    always_comb begin
        tdo = 1'b0;
        if (ir_shift)
            tdo = ir_so;
        else if (dr_shift) begin
            if (sel_idcode)
                tdo = idcode_so;
            else if (sel_user)
                tdo = user_so;
            else
                tdo = bypass_q;
        end
    end

endmodule

// File: tb/tb_jtag_data_regs.sv
module tb_jtag_data_regs;

    localparam int          IRW = 4;
    localparam int          UW  = 8;
    localparam logic [31:0] IDC = 32'h1234_5677;

    // strobe mask bit positions
    localparam int TLR = 1, CDR = 2, SDR = 4, UDR = 8, CIR = 16, SIR = 32, UIR = 64;

    logic           tck = 1'b0;
    logic           trst;
    logic           tdi;
    logic           tlr_s, cdr_s, sdr_s, udr_s, cir_s, sir_s, uir_s;
    logic [UW-1:0]  user_capture;
    logic           tdo, tdo_oe, user_update;
    logic [IRW-1:0] instruction;
    logic [UW-1:0]  user_out;

    int n_chk  = 0;
    int n_fail = 0;
    bit run    = 0;

    jtag_data_regs #(
        .IR_WIDTH     (IRW),
        .IDCODE_VALUE (IDC),
        .USER_WIDTH   (UW)
    ) dut (
        .tck                    (tck),
        .trst                   (trst),
        .tdi                    (tdi),
        .test_logic_reset_state (tlr_s),
        .capture_dr_state       (cdr_s),
        .shift_dr_state         (sdr_s),
        .update_dr_state        (udr_s),
        .capture_ir_state       (cir_s),
        .shift_ir_state         (sir_s),
        .update_ir_state        (uir_s),
        .user_capture           (user_capture),
        .tdo                    (tdo),
        .tdo_oe                 (tdo_oe),
        .instruction            (instruction),
        .user_out               (user_out),
        .user_update            (user_update)
    );

    always #5 tck = ~tck;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: registers held as plain integers ----
    int     m_instr, m_ir, m_usr, m_uo;
    longint m_idc;
    bit     m_byp, m_upd;

    always @(posedge tck) begin
        if (!trst) begin
            m_instr = 1; m_ir = 0; m_idc = 0; m_byp = 0; m_usr = 0; m_uo = 0; m_upd = 0;
        end else begin
            m_upd = 0;
            if (tlr_s)
                m_instr = 1;
            else if (cir_s || sir_s || uir_s) begin
                if (cir_s)      m_ir = 1;
                else if (sir_s) m_ir = (m_ir >> 1) | (int'(tdi) << (IRW - 1));
                else            m_instr = m_ir;
            end else if (m_instr == 1) begin
                if (cdr_s)      m_idc = longint'(IDC);
                else if (sdr_s) m_idc = (m_idc >> 1) | (longint'(tdi) << 31);
            end else if (m_instr == 2) begin
                if (cdr_s)      m_usr = int'(user_capture);
                else if (sdr_s) m_usr = (m_usr >> 1) | (int'(tdi) << (UW - 1));
                else if (udr_s) begin m_uo = m_usr; m_upd = 1; end
            end else begin
                if (cdr_s)      m_byp = 0;
                else if (sdr_s) m_byp = tdi;
            end
        end
    end

    function automatic logic exp_tdo();
        if (tlr_s) return 1'b0;
        if (cir_s || sir_s || uir_s) return (sir_s && !cir_s) ? logic'(m_ir & 1) : 1'b0;
        if (!sdr_s || cdr_s) return 1'b0;
        if (m_instr == 1) return logic'(m_idc & 1);
        if (m_instr == 2) return logic'(m_usr & 1);
        return m_byp;
    endfunction

    // ---- per-cycle compare against the model ----
    always @(negedge tck) begin
        if (run) begin
            chk("tdo",         64'(tdo),         64'(exp_tdo()));
            chk("tdo_oe",      64'(tdo_oe),      64'(sdr_s | sir_s));
            chk("instruction", 64'(instruction), 64'(m_instr));
            chk("user_out",    64'(user_out),    64'(m_uo));
            chk("user_update", 64'(user_update), 64'(m_upd));
        end
    end

    // one TAP cycle: drive strobes/tdi, sample tdo mid-cycle, advance past the edge
    task automatic cyc(input int mask, input logic t, output logic o);
        tlr_s = mask[0]; cdr_s = mask[1]; sdr_s = mask[2]; udr_s = mask[3];
        cir_s = mask[4]; sir_s = mask[5]; uir_s = mask[6];
        tdi   = t;
        @(negedge tck);
        o = tdo;
        @(posedge tck);
        #1;
    endtask

    task automatic load_ir(input logic [IRW-1:0] v);
        logic o;
        cyc(CIR, 1'b0, o);
        for (int i = 0; i < IRW; i++) cyc(SIR, v[i], o);
        cyc(UIR, 1'b0, o);
        cyc(0, 1'b0, o);
    endtask

    initial begin
        logic        o;
        logic [31:0] got;

        trst = 1'b0; tdi = 1'b0; user_capture = 8'hA5;
        tlr_s = 0; cdr_s = 0; sdr_s = 0; udr_s = 0; cir_s = 0; sir_s = 0; uir_s = 0;
        repeat (2) @(posedge tck);
        #1;
        run = 1;
        trst = 1'b1;
        chk("rst_instruction", 64'(instruction), 64'h1);
        chk("rst_user_out",    64'(user_out),    64'h0);
        chk("rst_tdo",         64'(tdo),         64'h0);
        chk("rst_tdo_oe",      64'(tdo_oe),      64'h0);

        // IDCODE readout
        cyc(0, 1'b0, o);
        cyc(CDR, 1'b0, o);
        got = '0;
        for (int i = 0; i < 32; i++) begin cyc(SDR, 1'b0, o); got[i] = o; end
        chk("idcode_stream", 64'(got), 64'h1234_5677);
        cyc(UDR, 1'b0, o);
        cyc(0, 1'b0, o);

        // IR capture pattern, load BYPASS
        cyc(CIR, 1'b0, o);
        got = '0;
        for (int i = 0; i < 4; i++) begin cyc(SIR, 1'b1, o); got[i] = o; end
        chk("ir_capture_stream", 64'(got[3:0]), 64'h1);
        cyc(UIR, 1'b0, o);
        chk("instr_bypass", 64'(instruction), 64'hF);
        cyc(0, 1'b0, o);

        // BYPASS: tdi 1,0,1,1 -> tdo 0,1,0,1
        cyc(CDR, 1'b0, o);
        got = '0;
        cyc(SDR, 1'b1, o); got[0] = o;
        cyc(SDR, 1'b0, o); got[1] = o;
        cyc(SDR, 1'b1, o); got[2] = o;
        cyc(SDR, 1'b1, o); got[3] = o;
        chk("bypass_stream", 64'(got[3:0]), 64'hA);
        cyc(UDR, 1'b0, o);
        cyc(0, 1'b0, o);

        // USER capture/shift/update
        load_ir(4'b0010);
        chk("instr_user", 64'(instruction), 64'h2);
        cyc(CDR, 1'b0, o);
        got = '0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'h3C;
            cyc(SDR, pat[i], o);
            got[i] = o;
        end
        chk("user_stream", 64'(got[7:0]), 64'hA5);
        cyc(UDR, 1'b0, o);
        chk("user_out_loaded", 64'(user_out),    64'h3C);
        chk("user_update_hi",  64'(user_update), 64'h1);
        cyc(0, 1'b0, o);
        chk("user_update_lo",  64'(user_update), 64'h0);

        // undefined opcode behaves as BYPASS; update-DR leaves user_out alone
        load_ir(4'b0111);
        cyc(CDR, 1'b0, o);
        cyc(SDR, 1'b1, o); got[0] = o;
        cyc(SDR, 1'b1, o); got[1] = o;
        chk("undef_bypass", 64'(got[1:0]), 64'h2);
        cyc(UDR, 1'b0, o);
        chk("undef_user_out", 64'(user_out), 64'h3C);
        cyc(0, 1'b0, o);

        // IR strobe beats a simultaneous DR strobe
        cyc(CIR | SDR, 1'b1, o);
        got = '0;
        for (int i = 0; i < 4; i++) begin cyc(SIR, 1'b1, o); got[i] = o; end
        chk("prio_ir_stream", 64'(got[3:0]), 64'h1);
        cyc(UIR, 1'b0, o);
        cyc(0, 1'b0, o);

        // Test-Logic-Reset restores IDCODE but keeps user_out
        load_ir(4'b0010);
        cyc(TLR, 1'b0, o);
        chk("tlr_instruction", 64'(instruction), 64'h1);
        chk("tlr_user_out",    64'(user_out),    64'h3C);
        cyc(0, 1'b0, o);

        // reset in the middle of a USER shift
        load_ir(4'b0010);
        cyc(CDR, 1'b0, o);
        for (int i = 0; i < 3; i++) cyc(SDR, 1'b1, o);
        trst = 1'b0;
        cyc(SDR, 1'b1, o);
        trst = 1'b1;
        chk("mid_rst_instruction", 64'(instruction), 64'h1);
        chk("mid_rst_user_out",    64'(user_out),    64'h0);
        chk("mid_rst_user_update", 64'(user_update), 64'h0);
        cyc(0, 1'b0, o);
        chk("mid_rst_tdo_oe", 64'(tdo_oe), 64'h0);
        chk("mid_rst_tdo",    64'(tdo),    64'h0);

        run = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
